// File: rtl/fpdiv_pkg.sv
// Shared definitions for the Goldschmidt divider: datapath mux select encodings,
// the sequencer state type and the per-state control word decode.
package fpdiv_pkg;

    localparam logic [1:0] MUXA_K  = 2'b00;
    localparam logic [1:0] MUXA_D  = 2'b01;
    localparam logic [1:0] MUXA_IA = 2'b10;

    localparam logic [1:0] MUXB_D  = 2'b00;
    localparam logic [1:0] MUXB_X  = 2'b01;
    localparam logic [1:0] MUXB_Q  = 2'b10;
    localparam logic [1:0] MUXB_DI = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StInitD,
        StInitQ,
        StIterQ,
        StIterD,
        StRem,
        StDone
    } state_e;

    typedef struct packed {
        logic [1:0] sel_muxa;
        logic [1:0] sel_muxb;
        logic       en_a;
        logic       en_b;
        logic       en_c;
        logic       en_r;
        logic       busy;
        logic       done;
    } ctrl_t;

    function automatic ctrl_t decode_state(state_e st);
        ctrl_t c;
        c      = '0;
        c.busy = (st != StIdle);
        unique case (st)
            StIdle: ;
            StInitD: begin
                c.sel_muxa = MUXA_IA;
                c.sel_muxb = MUXB_D;
                c.en_c     = 1'b1;
                c.en_a     = 1'b1;
            end
            StInitQ: begin
                c.sel_muxa = MUXA_IA;
                c.sel_muxb = MUXB_X;
                c.en_b     = 1'b1;
            end
            StIterQ: begin
                c.sel_muxa = MUXA_K;
                c.sel_muxb = MUXB_Q;
                c.en_b     = 1'b1;
            end
            // D and K load on the same edge, so this multiply still sees the old K.
            StIterD: begin
                c.sel_muxa = MUXA_K;
                c.sel_muxb = MUXB_DI;
                c.en_c     = 1'b1;
                c.en_a     = 1'b1;
            end
            StRem: begin
                c.sel_muxa = MUXA_D;
                c.sel_muxb = MUXB_Q;
                c.en_r     = 1'b1;
            end
            StDone: c.done = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/fpdiv_ctrl.sv
// Sequencer for the Goldschmidt divider datapath: seed scaling, ITERS refinement
// steps and the remainder product, with a start/done handshake and abort.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter int unsigned ITERS = 3,
    parameter int unsigned CNT_W = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic [1:0] sel_muxa,
    output logic [1:0] sel_muxb,
    output logic       enA,
    output logic       enB,
    output logic       enC,
    output logic       enR,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] LastIter = CNT_W'(ITERS - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   iter_cnt_q, iter_cnt_d;
    ctrl_t              ctrl_q;

    always_comb begin
        state_d    = state_q;
        iter_cnt_d = iter_cnt_q;
        if (abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            iter_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StInitD;
                StInitD: state_d = StInitQ;
                StInitQ: begin
                    state_d    = StIterQ;
                    iter_cnt_d = '0;
                end
                StIterQ: state_d = (iter_cnt_q == LastIter) ? StRem : StIterD;
                StIterD: begin
                    state_d    = StIterQ;
                    iter_cnt_d = iter_cnt_q + CNT_W'(1);
                end
                StRem:   state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Control word is registered from the next state so outputs come straight off flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= StIdle;
            iter_cnt_q <= '0;
            ctrl_q     <= '0;
        end else begin
            state_q    <= state_d;
            iter_cnt_q <= iter_cnt_d;
            ctrl_q     <= decode_state(state_d);
        end
    end

    assign sel_muxa = ctrl_q.sel_muxa;
    assign sel_muxb = ctrl_q.sel_muxb;
    assign enA      = ctrl_q.en_a;
    assign enB      = ctrl_q.en_b;
    assign enC      = ctrl_q.en_c;
    assign enR      = ctrl_q.en_r;
    assign busy     = ctrl_q.busy;
    assign done     = ctrl_q.done;

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
Sequencing FSM that drives the mux selects and register enables of the Goldschmidt divider datapath (fpdiv), which has no control of its own. The upstream issue logic calls it with a start/done handshake. It steps through seed scaling, ITERS refinement steps and the remainder product. Moore control only; no datapath arithmetic here.

Parameters:
ITERS, 3, number of Q refinement multiplies (legal 1..15); K/D refinements = ITERS-1.
CNT_W, 4, iteration counter width; must hold ITERS-1.

Ports:
clock     input   1  system clock, all state on rising edge
reset     input   1  synchronous, active-high
start     input   1  request new divide; sampled only in IDLE
abort     input   1  cancel current divide; any non-IDLE state
sel_muxa  output  2  datapath muxa select: 00 K(rega), 01 d, 10 ia seed
sel_muxb  output  2  datapath muxb select: 00 d, 01 x, 10 Q(regb), 11 D(regc)
enA       output  1  load rega (K = ~product)
enB       output  1  load regb (Q)
enC       output  1  load regc (D)
enR       output  1  load regr (d*Q for remainder)
busy      output  1  high in every state except IDLE
done      output  1  one-cycle pulse; regb/regr valid in this cycle

Behaviour:
- One clock; reset is synchronous, active-high, ports named clock and reset. Reset → state IDLE, iter_cnt=0, all outputs 0 (selects 00) from the next edge; any operation in progress is discarded; done is not pulsed.
- States and Moore outputs (unlisted enables 0):
  - IDLE: selects 00. Goes to INIT_D if start=1.
  - INIT_D: muxa=10, muxb=00, enC=1, enA=1. D0=ia*d; K0=~D0. Goes to INIT_Q.
  - INIT_Q: muxa=10, muxb=01, enB=1. Q0=ia*x. Goes to ITER_Q; iter_cnt=0.
  - ITER_Q: muxa=00, muxb=10, enB=1.
    - If iter_cnt==ITERS-1, goes to REM.
    - Otherwise goes to ITER_D.
  - ITER_D: muxa=00, muxb=11, enC=1, enA=1. Both D and K load on the same edge, so the K used is the old value. iter_cnt++; goes to ITER_Q.
  - REM: muxa=01, muxb=10, enR=1. Goes to DONE.
  - DONE: done=1, all enables 0. Goes to IDLE unconditionally.
- Latency: start sampled at edge k gives done high in cycle k+3+2*ITERS (ITERS=3: cycle k+9). Throughput is one divide per 2*ITERS+4 cycles, since IDLE is always visited for one cycle.
- start in any state other than IDLE is ignored; no queuing.
- abort=1 in any non-IDLE state, DONE included, returns to IDLE on the next edge.
  - All enables are 0 in that following cycle; done stays 0 if not yet pulsed.
  - abort takes priority over every other transition; reset takes priority over abort.
- Invariants:
  - enR=1 only in REM; enA=1 only together with enC=1.
  - At most two enables are high per cycle.
  - Selects never take muxa=11 (undefined in the datapath).
- Upstream holds d and x stable from the start edge through done; this block does not capture operands.
- Outputs are decoded from the state register only; no combinational path from start or abort to the outputs.
- iter_cnt does not wrap within an operation; its maximum value is ITERS-1.

Decomposition:
- Package fpdiv_pkg holds:
  - the state enum (IDLE, INIT_D, INIT_Q, ITER_Q, ITER_D, REM, DONE);
  - MUXA_K=2'b00, MUXA_D=2'b01, MUXA_IA=2'b10;
  - MUXB_D=2'b00, MUXB_X=2'b01, MUXB_Q=2'b10, MUXB_DI=2'b11.
- Datapath fpdiv imports the same select constants.
- Single module, no sub-module. The counter and FSM are under 150 lines combined.

Test Plan:
- Reset held 3 cycles, then released with start=0 → all outputs 0, busy=0, state IDLE indefinitely.
- ITERS=3, start pulse at edge 0 → per-cycle selects/enables are:
  - c1 (10,00,A+C), c2 (10,01,B), c3 (00,10,B), c4 (00,11,A+C);
  - c5 (00,10,B), c6 (00,11,A+C), c7 (00,10,B), c8 (01,10,R);
  - c9 done=1 for exactly 1 cycle, busy=0 at c10.
- start held high continuously → second INIT_D at c11 (IDLE at c10); start pulses during c1–c9 have no effect.
- abort=1 in cycle c4 (ITER_D) → c5 IDLE, all enables 0, done never asserted; a new start at c5 gives a full clean sequence.
- reset=1 in cycle c6 → c7 IDLE, outputs 0, iter_cnt=0, no done; the next operation sequence is identical to the second scenario.
- ITERS=1 → sequence INIT_D, INIT_Q, ITER_Q, REM, DONE; ITER_D never entered; done at k+5.
